// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the Ram2 SRAM arbiter between instruction fetch and data memory.
package mem_arb_pkg;

    localparam int RAM_ADDR_W_DEF = 18;
    localparam int WR_CNT_W       = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WS   = 3'd2,
        WP   = 3'd3,
        WH   = 3'd4,
        DONE = 3'd5
    } arb_state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } gnt_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side request ports and SRAM pins of mem_arbiter; slave is the arbiter side.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int RAM_ADDR_W = RAM_ADDR_W_DEF
);
    logic                  if_req;
    logic [15:0]           if_addr;
    logic [15:0]           if_rdata;
    logic                  if_ack;

    logic                  dm_req;
    logic                  dm_we;
    logic [15:0]           dm_addr;
    logic [15:0]           dm_wdata;
    logic [15:0]           dm_rdata;
    logic                  dm_ack;

    logic                  stall;

    logic [RAM_ADDR_W-1:0] ram_addr;
    logic [15:0]           ram_dout;
    logic [15:0]           ram_din;
    logic                  ram_drive;
    logic                  ram_en_n;
    logic                  ram_oe_n;
    logic                  ram_we_n;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_din,
        output if_rdata, if_ack, dm_rdata, dm_ack, stall,
               ram_addr, ram_dout, ram_drive, ram_en_n, ram_oe_n, ram_we_n
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_din,
        input  if_rdata, if_ack, dm_rdata, dm_ack, stall,
               ram_addr, ram_dout, ram_drive, ram_en_n, ram_oe_n, ram_we_n
    );

endinterface

// File: rtl/wr_pulse_timer.sv
// Down-counter timing the write-enable low pulse; tc marks the last pulse cycle.
module wr_pulse_timer
    import mem_arb_pkg::*;
#(
    parameter int WR_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);

    logic [WR_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = WR_CNT_W'(WR_CYCLES);
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - WR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == WR_CNT_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Ram2 SRAM controller and IF/DM arbiter with multi-cycle read/write sequencing.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of fixed DM priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WR_CYCLES  = 2,
    parameter int RAM_ADDR_W = RAM_ADDR_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    arb_state_e  state_q, state_d;
    gnt_e        gnt_q, gnt_d;
    gnt_e        gnt_sel;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] if_rdata_q, if_rdata_d;
    logic [15:0] dm_rdata_q, dm_rdata_d;
    logic        wr_tc;
    logic        if_ack, dm_ack;
`ifdef MEM_ARB_RR_EN
    gnt_e        last_gnt_q, last_gnt_d;
`endif

    wr_pulse_timer #(
        .WR_CYCLES (WR_CYCLES)
    ) u_wr_pulse_timer (
        .clk  (clk),
        .rst  (rst),
        .load (state_q == WS),
        .en   (state_q == WP),
        .tc   (wr_tc)
    );

    always_comb begin
`ifdef MEM_ARB_RR_EN
        if (bus.dm_req && bus.if_req) begin
            gnt_sel = (last_gnt_q == GNT_DM) ? GNT_IF : GNT_DM;
        end else begin
            gnt_sel = bus.dm_req ? GNT_DM : GNT_IF;
        end
`else
        gnt_sel = bus.dm_req ? GNT_DM : GNT_IF;
`endif
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_gnt_d = last_gnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    gnt_d   = gnt_sel;
                    addr_d  = (gnt_sel == GNT_DM) ? bus.dm_addr : bus.if_addr;
                    wdata_d = bus.dm_wdata;
                    state_d = ((gnt_sel == GNT_DM) && bus.dm_we) ? WS : RD;
`ifdef MEM_ARB_RR_EN
                    last_gnt_d = gnt_sel;
`endif
                end
            end
            RD: begin
                if (gnt_q == GNT_DM) begin
                    dm_rdata_d = bus.ram_din;
                end else begin
                    if_rdata_d = bus.ram_din;
                end
                state_d = DONE;
            end
            WS:      state_d = WP;
            WP:      if (wr_tc) state_d = WH;
            WH:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            gnt_q      <= GNT_DM;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_gnt_q <= GNT_DM;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_gnt_q <= last_gnt_d;
`endif
        end
    end

    // Chip stays enabled for the whole write so WE can toggle inside a selected cycle.
    assign bus.ram_en_n  = !((state_q == RD) || (state_q == WS) ||
                             (state_q == WP) || (state_q == WH));
    assign bus.ram_oe_n  = (state_q != RD);
    assign bus.ram_we_n  = (state_q != WP);
    assign bus.ram_drive = (state_q == WS) || (state_q == WP) || (state_q == WH);

    assign if_ack = (state_q == DONE) && (gnt_q == GNT_IF);
    assign dm_ack = (state_q == DONE) && (gnt_q == GNT_DM);

    assign bus.if_ack   = if_ack;
    assign bus.dm_ack   = dm_ack;
    assign bus.stall    = (bus.if_req & ~if_ack) | (bus.dm_req & ~dm_ack);
    assign bus.if_rdata = if_rdata_q;
    assign bus.dm_rdata = dm_rdata_q;
    assign bus.ram_addr = RAM_ADDR_W'(addr_q);
    assign bus.ram_dout = wdata_q;

endmodule
